// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial BCD sequencer feeding an external
// combinational single-digit BCD adder, LSD first, carry rippled via a flop.
// Optional macro BCD_SERIAL_SUB_EN adds input sub (A-B, ten's complement).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start, a, b, cin  request and packed BCD operands (sampled in IDLE)
//   dig_x, dig_y, dig_cin  digit operands/carry to the digit adder
//   dig_sum, dig_cout      digit adder result (same cycle)
//   busy, done, err        RUN flag, completion pulse, bad-digit flag
//   sum, cout              registered result and final decimal carry
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SERIAL_SUB_EN
  input  logic                sub,
`endif
  output logic [3:0]          dig_x,
  output logic [3:0]          dig_y,
  output logic                dig_cin,
  input  logic [3:0]          dig_sum,
  input  logic                dig_cout,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  part_q, part_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          c_q, c_d;
  logic          cout_q, cout_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          bad;
  logic          last;
  logic [W-1:0]  b_lat;
  logic          c_lat;
  logic [W+3:0]  shf;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i+:4] > 4'd9 || b[4*i+:4] > 4'd9) bad = 1'b1;
    end
  end

  // Subtraction: nines' complement of B plus a forced carry-in.
`ifdef BCD_SERIAL_SUB_EN
  always_comb begin
    b_lat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b_lat[4*i+:4] = sub ? (4'd9 - b[4*i+:4]) : b[4*i+:4];
    end
    c_lat = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_lat = b;
    c_lat = cin;
  end
`endif

  assign last = (cnt_q == CW'(DIGITS - 1));

  // Extra nibble on top keeps the shift legal for DIGITS == 1.
  assign shf = {dig_sum, part_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !bad) state_d = RUN;
      RUN:  if (last)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN);
    dig_x   = busy ? a_q[3:0] : 4'd0;
    dig_y   = busy ? b_q[3:0] : 4'd0;
    dig_cin = busy ? c_q : 1'b0;
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    part_d = part_q;
    sum_d  = sum_q;
    c_d    = c_q;
    cout_d = cout_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && bad) begin
          err_d  = 1'b1;
          sum_d  = '0;
          cout_d = 1'b0;
          done_d = 1'b1;
        end else if (start) begin
          a_d    = a;
          b_d    = b_lat;
          c_d    = c_lat;
          part_d = '0;
          cnt_d  = '0;
          err_d  = 1'b0;
        end
      end
      RUN: begin
        part_d = shf[W+3:4];
        c_d    = dig_cout;
        a_d    = a_q >> 4;
        b_d    = b_q >> 4;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          sum_d  = shf[W+3:4];
          cout_d = dig_cout;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      part_q <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      part_q <= part_d;
      sum_q  <= sum_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed bench for bcd_serial_adder (DIGITS=4)
// with a behavioural single-digit BCD adder closing the loop.
module tb_bcd_serial_adder;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4*D-1:0] a, b;
  logic          cin;
`ifdef BCD_SERIAL_SUB_EN
  logic          sub;
`endif
  logic [3:0]    dig_x, dig_y, dig_sum;
  logic          dig_cin, dig_cout;
  logic          busy, done, err, cout;
  logic [4*D-1:0] sum;

  int checks = 0;
  int errors = 0;
  logic cin_log [D];
  logic [15:0] last_sum = 16'h0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(D)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef BCD_SERIAL_SUB_EN
    .sub      (sub),
`endif
    .dig_x    (dig_x),
    .dig_y    (dig_y),
    .dig_cin  (dig_cin),
    .dig_sum  (dig_sum),
    .dig_cout (dig_cout),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sum      (sum),
    .cout     (cout)
  );

  logic [4:0] t;
  always_comb begin
    t = {1'b0, dig_x} + {1'b0, dig_y} + {4'b0, dig_cin};
    dig_cout = (t > 5'd9);
    dig_sum  = dig_cout ? 4'(t - 5'd10) : t[3:0];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] nines(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < D; i++) r[4*i+:4] = 4'd9 - v[4*i+:4];
    return r;
  endfunction

  task automatic op(input string tag, input logic [15:0] av, bv,
                    input logic cv, sv, pk,
                    input logic [15:0] es, input logic ec);
    logic [15:0] ey;
    ey    = sv ? nines(bv) : bv;
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
`ifdef BCD_SERIAL_SUB_EN
    sub   = sv;
`endif
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (pk && k == 1) begin
        start = 1'b1;
        a     = 16'h9999;
        b     = 16'h9999;
      end
      if (pk && k == 2) start = 1'b0;
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".done_run"}, done, 1'b0);
      chk({tag, ".dig_x"}, dig_x, av[4*k+:4]);
      chk({tag, ".dig_y"}, dig_y, ey[4*k+:4]);
      chk({tag, ".sum_hold"}, sum, last_sum);
      cin_log[k] = dig_cin;
    end
    @(negedge clk);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".busy_end"}, busy, 1'b0);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".err"}, err, 1'b0);
    last_sum = es;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef BCD_SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.sum", sum, 16'h0);
    chk("rst.cout", cout, 1'b0);
    chk("rst.dig_x", dig_x, 4'h0);
    chk("rst.dig_y", dig_y, 4'h0);
    chk("rst.dig_cin", dig_cin, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    op("add1", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 16'h6912, 1'b0);
    op("c9999", 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("c9999.cin0", cin_log[0], 1'b0);
    chk("c9999.cin1", cin_log[1], 1'b1);
    chk("c9999.cin2", cin_log[2], 1'b1);
    chk("c9999.cin3", cin_log[3], 1'b1);

    op("cin1", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0);
    op("b2b", 16'h0500, 16'h0500, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0);

    start = 1'b1;
    a     = 16'h12A4;
    b     = 16'h0000;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("bad.busy", busy, 1'b0);
    chk("bad.done", done, 1'b1);
    chk("bad.err", err, 1'b1);
    chk("bad.sum", sum, 16'h0);
    chk("bad.cout", cout, 1'b0);
    chk("bad.dig_x", dig_x, 4'h0);
    @(negedge clk);
    chk("bad.done_off", done, 1'b0);
    chk("bad.busy_off", busy, 1'b0);
    chk("bad.err_hold", err, 1'b1);
    last_sum = 16'h0;

    op("clr", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 16'h6912, 1'b0);
    @(negedge clk);
    chk("clr.done_off", done, 1'b0);

    op("poke", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0);
    @(negedge clk);
    chk("poke.busy_after", busy, 1'b0);
    chk("poke.done_after", done, 1'b0);

    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", busy, 1'b0);
    chk("mid.done", done, 1'b0);
    chk("mid.sum", sum, 16'h0);
    chk("mid.cout", cout, 1'b0);
    chk("mid.dig_x", dig_x, 4'h0);
    chk("mid.dig_cin", dig_cin, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid.no_done", done, 1'b0);
      chk("mid.idle", busy, 1'b0);
    end
    last_sum = 16'h0;

`ifdef BCD_SERIAL_SUB_EN
    op("sub1", 16'h5000, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h3766, 1'b1);
    op("sub2", 16'h1234, 16'h5000, 1'b1, 1'b1, 1'b0, 16'h6234, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
